// File: rtl/aes128_arbiter.sv
// Round-robin sharing of one aes128 core between NUM_REQ block streams,
// with key reload on owner change and an in-order tag FIFO for result routing.
module aes128_arbiter #(
    parameter int NUM_REQ         = 4,
    parameter int MAX_BURST       = 16,
    parameter int KEY_WAIT_CYCLES = 11,
    parameter int TAG_DEPTH       = 32
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [NUM_REQ*128-1:0] req_key,
    input  logic [NUM_REQ*128-1:0] req_data,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic [127:0]           rsp_data,
    output logic [NUM_REQ-1:0]     rsp_valid,
    output logic [127:0]           aes_key_out,
    output logic                   aes_key_valid_out,
    output logic [127:0]           aes_data_out,
    output logic                   aes_valid_out,
    input  logic [127:0]           aes_data_in,
    input  logic                   aes_valid_in,
    output logic                   busy,
    output logic                   tag_error
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int PW = $clog2(TAG_DEPTH);
    localparam int CW = PW + 1;
    localparam int BW = $clog2(MAX_BURST) + 1;
    localparam int WW = $clog2(KEY_WAIT_CYCLES + 2);

    typedef enum logic [2:0] {
        IDLE, DRAIN, KEY_LOAD, KEY_WAIT, STREAM
    } state_t;

    state_t             state_q, state_d;
    logic [IW-1:0]      rr_q, rr_d;
    logic [IW-1:0]      grant_q, grant_d;
    logic [BW-1:0]      burst_cnt_q, burst_cnt_d;
    logic [WW-1:0]      wait_cnt_q, wait_cnt_d;
    logic               key_loaded_q, key_loaded_d;
    logic [127:0]       loaded_key_q, loaded_key_d;
    logic [127:0]       aes_data_q, aes_data_d;
    logic               aes_valid_q, aes_valid_d;
    logic [127:0]       rsp_data_q, rsp_data_d;
    logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
    logic               tag_error_q, tag_error_d;
    logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      count_q, count_d;
    logic [IW-1:0]      tag_mem_q [TAG_DEPTH];

    logic [127:0]  key_arr  [NUM_REQ];
    logic [127:0]  data_arr [NUM_REQ];
    logic [IW-1:0] pick;
    logic          pick_vld;
    logic          fifo_full, fifo_empty;
    logic          hs, push, pop;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign key_arr[g]  = req_key[g*128 +: 128];
        assign data_arr[g] = req_data[g*128 +: 128];
    end

    assign fifo_full  = (count_q == CW'(TAG_DEPTH));
    assign fifo_empty = (count_q == '0);
    assign hs   = (state_q == STREAM) && req_valid[grant_q] && !fifo_full;
    assign push = hs;
    assign pop  = aes_valid_in && !fifo_empty;

    // Walk downward so the nearest valid requester after rr wins.
    always_comb begin
        pick     = rr_q;
        pick_vld = 1'b0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            if (req_valid[IW'((int'(rr_q) + i) % NUM_REQ)]) begin
                pick     = IW'((int'(rr_q) + i) % NUM_REQ);
                pick_vld = 1'b1;
            end
        end
    end

    always_comb begin
        state_d           = state_q;
        rr_d              = rr_q;
        grant_d           = grant_q;
        burst_cnt_d       = burst_cnt_q;
        wait_cnt_d        = wait_cnt_q;
        key_loaded_d      = key_loaded_q;
        loaded_key_d      = loaded_key_q;
        aes_key_valid_out = 1'b0;
        aes_key_out       = '0;
        unique case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    grant_d     = pick;
                    rr_d        = pick;
                    burst_cnt_d = '0;
                    if (key_loaded_q && key_arr[pick] == loaded_key_q)
                        state_d = STREAM;
                    else
                        state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (fifo_empty) state_d = KEY_LOAD;
            end
            KEY_LOAD: begin
                aes_key_valid_out = 1'b1;
                aes_key_out       = key_arr[grant_q];
                loaded_key_d      = key_arr[grant_q];
                key_loaded_d      = 1'b1;
                wait_cnt_d        = WW'(KEY_WAIT_CYCLES);
                state_d = (KEY_WAIT_CYCLES == 0) ? STREAM : KEY_WAIT;
            end
            KEY_WAIT: begin
                wait_cnt_d = wait_cnt_q - WW'(1);
                if (wait_cnt_q == WW'(1)) state_d = STREAM;
            end
            STREAM: begin
                if (!req_valid[grant_q]) begin
                    state_d = IDLE;
                end else if (hs) begin
                    burst_cnt_d = burst_cnt_q + BW'(1);
                    if (burst_cnt_q == BW'(MAX_BURST - 1)) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        aes_valid_d = hs;
        aes_data_d  = hs ? data_arr[grant_q] : aes_data_q;
        wr_ptr_d    = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d    = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d     = count_q;
        if (push && !pop)
            count_d = count_q + CW'(1);
        else if (pop && !push)
            count_d = count_q - CW'(1);
        rsp_valid_d = '0;
        rsp_data_d  = rsp_data_q;
        tag_error_d = tag_error_q;
        if (pop) begin
            rsp_valid_d = NUM_REQ'(1) << tag_mem_q[rd_ptr_q];
            rsp_data_d  = aes_data_in;
        end else if (aes_valid_in) begin
            tag_error_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            rr_q         <= '0;
            grant_q      <= '0;
            burst_cnt_q  <= '0;
            wait_cnt_q   <= '0;
            key_loaded_q <= 1'b0;
            loaded_key_q <= '0;
            aes_data_q   <= '0;
            aes_valid_q  <= 1'b0;
            rsp_data_q   <= '0;
            rsp_valid_q  <= '0;
            tag_error_q  <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            rr_q         <= rr_d;
            grant_q      <= grant_d;
            burst_cnt_q  <= burst_cnt_d;
            wait_cnt_q   <= wait_cnt_d;
            key_loaded_q <= key_loaded_d;
            loaded_key_q <= loaded_key_d;
            aes_data_q   <= aes_data_d;
            aes_valid_q  <= aes_valid_d;
            rsp_data_q   <= rsp_data_d;
            rsp_valid_q  <= rsp_valid_d;
            tag_error_q  <= tag_error_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) tag_mem_q[wr_ptr_q] <= grant_q;
    end

    assign req_ready     = hs ? (NUM_REQ'(1) << grant_q) : '0;
    assign aes_data_out  = aes_data_q;
    assign aes_valid_out = aes_valid_q;
    assign rsp_data      = rsp_data_q;
    assign rsp_valid     = rsp_valid_q;
    assign tag_error     = tag_error_q;
    assign busy          = (state_q != IDLE) || !fifo_empty;
endmodule

// File: tb/tb_aes128_arbiter.sv
// Directed bench for aes128_arbiter: XOR core model with settable latency,
// owner/data scoreboard, and arbitration, key reload and backpressure checks.
`timescale 1ns/1ps
module tb_aes128_arbiter;
    localparam int N = 4;
    localparam logic [127:0] K  = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
    localparam logic [127:0] K3 = 128'h00010203_04050607_08090a0b_0c0d0e0f;

    typedef struct { int due; logic [127:0] d; } core_t;
    typedef struct { int own; logic [127:0] d; } exp_t;

    logic           clk = 1'b0;
    logic           reset_n;
    logic [N*128-1:0] req_key, req_data;
    logic [N-1:0]   req_valid, req_ready, rsp_valid;
    logic [127:0]   rsp_data, aes_key_out, aes_data_out, aes_data_in;
    logic           aes_key_valid_out, aes_valid_out, aes_valid_in;
    logic           busy, tag_error;
    logic           core_v, inj_v;
    logic [127:0]   core_d, core_key, kp_key;
    logic [127:0]   src_data [N];
    logic [127:0]   src_key  [N];
    int             src_left [N];
    int             last_rsp_cyc [N];

    core_t core_q[$];
    exp_t  exp_q[$];
    int    hs_own[$];
    int    hs_cyc[$];

    int checks = 0, failures = 0;
    int cyc = 0, lat = 5, kp = 0, kp_cyc = 0;
    int issued = 0, rsps = 0, outst = 0, max_out = 0;
    int stall_seen = 0, resume_cyc = -1, first_rsp_cyc = -1;
    int nb;
    logic [31:0] owns, lens;

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_pack
        assign req_key[g*128 +: 128]  = src_key[g];
        assign req_data[g*128 +: 128] = src_data[g];
    end
    assign aes_valid_in = core_v | inj_v;
    assign aes_data_in  = core_d;

    aes128_arbiter dut (
        .clk(clk), .reset_n(reset_n),
        .req_key(req_key), .req_data(req_data),
        .req_valid(req_valid), .req_ready(req_ready),
        .rsp_data(rsp_data), .rsp_valid(rsp_valid),
        .aes_key_out(aes_key_out), .aes_key_valid_out(aes_key_valid_out),
        .aes_data_out(aes_data_out), .aes_valid_out(aes_valid_out),
        .aes_data_in(aes_data_in), .aes_valid_in(aes_valid_in),
        .busy(busy), .tag_error(tag_error)
    );

    task automatic check(input string tag, input logic [127:0] got,
                         input logic [127:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One clock: observe at negedge, update sources and core after posedge.
    task automatic step();
        logic [N-1:0] hsm;
        exp_t  e;
        core_t c;
        @(negedge clk);
        cyc++;
        hsm = '0;
        if (aes_key_valid_out === 1'b1) begin
            kp++;
            kp_cyc   = cyc;
            kp_key   = aes_key_out;
            core_key = aes_key_out;
        end
        if (aes_valid_out === 1'b1) begin
            c.due = cyc + lat;
            c.d   = aes_data_out ^ core_key;
            core_q.push_back(c);
        end
        for (int i = 0; i < N; i++) begin
            if (req_valid[i] && req_ready[i] === 1'b1) begin
                hsm[i] = 1'b1;
                e.own  = i;
                e.d    = src_data[i] ^ src_key[i];
                exp_q.push_back(e);
                hs_own.push_back(i);
                hs_cyc.push_back(cyc);
                issued++;
                if (stall_seen != 0 && resume_cyc < 0) resume_cyc = cyc;
            end
        end
        if (rsp_valid !== '0) begin
            if (exp_q.size() == 0) begin
                check("rsp_unexpected", 128'(rsp_valid), 128'(0));
            end else begin
                e = exp_q.pop_front();
                check("rsp_owner", 128'(rsp_valid), 128'(32'(1) << e.own));
                check("rsp_data", rsp_data, e.d);
                rsps++;
                last_rsp_cyc[e.own] = cyc;
                if (first_rsp_cyc < 0) first_rsp_cyc = cyc;
            end
        end
        outst = issued - rsps;
        if (outst > max_out) max_out = outst;
        if (req_valid[0] && req_ready[0] === 1'b0 && outst == 32)
            stall_seen = 1;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (hsm[i]) begin
                src_left[i]--;
                src_data[i] = src_data[i] + 128'd1;
                req_valid[i] = (src_left[i] > 0);
            end
        end
        if (core_q.size() > 0 && core_q[0].due <= cyc) begin
            c = core_q.pop_front();
            core_v = 1'b1;
            core_d = c.d;
        end else begin
            core_v = 1'b0;
        end
    endtask

    task automatic start(input int i, input int n, input logic [127:0] key);
        src_key[i]   = key;
        src_left[i]  = n;
        req_valid[i] = (n > 0);
    endtask

    task automatic wait_done(input string tag, input int limit);
        int  n;
        logic done;
        n = 0;
        done = 1'b0;
        while (!done && n < limit) begin
            step();
            n++;
            done = (busy === 1'b0) && core_q.size() == 0 &&
                   exp_q.size() == 0 && core_v == 1'b0 && req_valid == '0;
        end
        check(tag, 128'(done), 128'(1));
    endtask

    task automatic new_phase();
        hs_own.delete();
        hs_cyc.delete();
        kp = 0;
        issued = 0;
        rsps = 0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        step();
        step();
        reset_n = 1'b1;
        core_q.delete();
        exp_q.delete();
        new_phase();
    endtask

    function automatic logic [31:0] pack_owners();
        logic [31:0] v = '0;
        for (int k = 0; k < hs_own.size(); k++) v = (v << 4) | 32'(hs_own[k]);
        return v;
    endfunction

    task automatic bursts(output int n, output logic [31:0] o,
                          output logic [31:0] l);
        int len;
        n = 0; o = '0; l = '0; len = 0;
        for (int k = 0; k < hs_own.size(); k++) begin
            if (k > 0 && (hs_own[k] != hs_own[k-1] ||
                          hs_cyc[k] != hs_cyc[k-1] + 1)) begin
                n++;
                o = (o << 4) | 32'(hs_own[k-1]);
                l = (l << 8) | 32'(len);
                len = 0;
            end
            len++;
        end
        if (len > 0) begin
            n++;
            o = (o << 4) | 32'(hs_own[hs_own.size()-1]);
            l = (l << 8) | 32'(len);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        req_valid = '0;
        core_v = 1'b0;
        inj_v = 1'b0;
        core_d = '0;
        core_key = '0;
        kp_key = '0;
        for (int i = 0; i < N; i++) begin
            src_data[i] = {32'hDA7A0000 + 32'(i), 96'd0};
            src_key[i]  = '0;
            src_left[i] = 0;
            last_rsp_cyc[i] = -1;
        end

        // All four valid through reset; first grant must go to requester 1.
        for (int i = 0; i < N; i++) start(i, 2, K);
        step();
        step();
        check("rst_ready", 128'(req_ready), 128'(0));
        check("rst_rsp_valid", 128'(rsp_valid), 128'(0));
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_tag_error", 128'(tag_error), 128'(0));
        check("rst_aes_valid", 128'(aes_valid_out), 128'(0));
        check("rst_key_valid", 128'(aes_key_valid_out), 128'(0));
        reset_n = 1'b1;
        new_phase();
        wait_done("a_done", 300);
        check("a_order", 128'(pack_owners()), 128'(32'h11223300));
        check("a_key_pulses", 128'(kp), 128'(1));
        check("a_key_value", kp_key, K);
        check("a_key_wait", 128'(hs_cyc[0] - kp_cyc), 128'(12));

        // Single requester, 40 blocks: bursts 16/16/8, one key load.
        do_reset();
        start(0, 40, K);
        wait_done("b_done", 400);
        bursts(nb, owns, lens);
        check("b_bursts", 128'(nb), 128'(3));
        check("b_lens", 128'(lens), 128'(32'h00101008));
        check("b_owners", 128'(owns), 128'(0));
        check("b_key_pulses", 128'(kp), 128'(1));
        check("b_rsps", 128'(rsps), 128'(40));

        // Shared key: alternating bursts, no reload.
        new_phase();
        start(0, 24, K);
        start(2, 24, K);
        wait_done("c_done", 400);
        bursts(nb, owns, lens);
        check("c_bursts", 128'(nb), 128'(4));
        check("c_owners", 128'(owns), 128'(32'h2020));
        check("c_lens", 128'(lens), 128'(32'h10100808));
        check("c_key_pulses", 128'(kp), 128'(0));
        check("c_rsps", 128'(rsps), 128'(48));

        // Key change: drain requester 1 results before loading K3.
        new_phase();
        lat = 20;
        start(1, 4, K);
        start(3, 4, K3);
        wait_done("d_done", 400);
        check("d_order", 128'(pack_owners()), 128'(32'h11113333));
        check("d_key_pulses", 128'(kp), 128'(1));
        check("d_key_value", kp_key, K3);
        check("d_pulse_after_drain",
              128'(kp_cyc > last_rsp_cyc[1]), 128'(1));
        check("d_issue_after_drain",
              128'(hs_cyc[4] > last_rsp_cyc[1]), 128'(1));
        check("d_key_wait", 128'(hs_cyc[4] - kp_cyc), 128'(12));

        // Long core latency: FIFO fills at 32 and resumes on first response.
        new_phase();
        lat = 40;
        max_out = 0;
        stall_seen = 0;
        resume_cyc = -1;
        first_rsp_cyc = -1;
        start(0, 48, K3);
        wait_done("e_done", 800);
        check("e_max_outstanding", 128'(max_out), 128'(32));
        check("e_stall_seen", 128'(stall_seen), 128'(1));
        check("e_resume_on_rsp", 128'(resume_cyc), 128'(first_rsp_cyc));
        check("e_key_pulses", 128'(kp), 128'(0));
        check("e_rsps", 128'(rsps), 128'(48));
        check("e_tag_error", 128'(tag_error), 128'(0));

        // Spurious core output with nothing in flight.
        core_d = 128'hBAD0BAD0;
        inj_v = 1'b1;
        step();
        inj_v = 1'b0;
        step();
        check("f_tag_error", 128'(tag_error), 128'(1));
        check("f_rsp_valid", 128'(rsp_valid), 128'(0));
        step();
        step();
        step();
        check("f_tag_sticky", 128'(tag_error), 128'(1));
        check("f_busy", 128'(busy), 128'(0));
        reset_n = 1'b0;
        step();
        check("f_reset_clears", 128'(tag_error), 128'(0));
        reset_n = 1'b1;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
